clk_gate_ctrl: RTL and testbench

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_ctrl_if.sv | 25 ++
 rtl/clk_gate_ctrl.sv | 120 ++++++++++++
 tb/tb_clk_gate_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/clk_gate_ctrl_if.sv
// Control/status bundle between the gating controller and its user.
// The master side drives the requests; the slave side is the controller.
interface clk_gate_if #(
  parameter int CNT_W = 8
);
  logic             auto_en;
  logic             busy;
  logic             wake;
  logic [CNT_W-1:0] idle_thresh;
  logic             quiesce_ack;
  logic             quiesce_req;
  logic             clk_en;
  logic             clk_ready;
  logic [2:0]       state;

  modport master (
    output auto_en, busy, wake, idle_thresh, quiesce_ack,
    input  quiesce_req, clk_en, clk_ready, state
  );

  modport slave (
    input  auto_en, busy, wake, idle_thresh, quiesce_ack,
    output quiesce_req, clk_en, clk_ready, state
  );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Idle-driven clock gating FSM with a quiesce handshake and a timed wake-up;
// every output comes straight from a flop so the ICG enable never glitches.
module clk_gate_ctrl #(
  parameter int CNT_W    = 8,
  parameter int WAKE_DLY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  clk_gate_if.slave   gif
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    IDLE_CNT = 3'd1,
    QUIESCE  = 3'd2,
    OFF      = 3'd3,
    WAKE     = 3'd4
  } state_t;

  localparam logic [3:0] WAKE_LAST = 4'(WAKE_DLY);

  state_t           cur, nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
  logic [3:0]       wake_cnt, wake_cnt_nxt;
  logic             en_q, rdy_q, qreq_q;
  logic             en_d, rdy_d, qreq_d;
  logic             idle_ok;
  logic [CNT_W-1:0] thresh_m1;

  assign idle_ok   = gif.auto_en && !gif.busy && !gif.wake && (gif.idle_thresh != '0);
  assign thresh_m1 = gif.idle_thresh - CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= RUN;
      idle_cnt <= '0;
      wake_cnt <= '0;
      en_q     <= 1'b1;
      rdy_q    <= 1'b1;
      qreq_q   <= 1'b0;
    end else begin
      cur      <= nxt;
      idle_cnt <= idle_cnt_nxt;
      wake_cnt <= wake_cnt_nxt;
      en_q     <= en_d;
      rdy_q    <= rdy_d;
      qreq_q   <= qreq_d;
    end
  end

  always_comb begin
    nxt          = cur;
    idle_cnt_nxt = idle_cnt;
    wake_cnt_nxt = wake_cnt;
    case (cur)
      RUN: begin
        if (idle_ok) begin
          nxt          = IDLE_CNT;
          idle_cnt_nxt = '0;
        end
      end
      IDLE_CNT: begin
        if (!idle_ok) begin
          nxt          = RUN;
          idle_cnt_nxt = '0;
        end else if (idle_cnt == thresh_m1) begin
          nxt          = QUIESCE;
          idle_cnt_nxt = '0;
        end else begin
          idle_cnt_nxt = idle_cnt + CNT_W'(1);
        end
      end
      QUIESCE: begin
        // Activity or a wake request wins over a late ack.
        if (gif.busy || gif.wake || !gif.auto_en) nxt = RUN;
        else if (gif.quiesce_ack)                 nxt = OFF;
      end
      OFF: begin
        if (gif.wake || gif.busy || !gif.auto_en) begin
          nxt          = WAKE;
          wake_cnt_nxt = '0;
        end
      end
      WAKE: begin
        if (wake_cnt == WAKE_LAST) begin
          nxt          = RUN;
          wake_cnt_nxt = '0;
        end else begin
          wake_cnt_nxt = wake_cnt + 4'd1;
        end
      end
      default: begin
        nxt          = RUN;
        idle_cnt_nxt = '0;
        wake_cnt_nxt = '0;
      end
    endcase
  end

  // Decode the upcoming state so the registered outputs track the state flop.
  always_comb begin
    en_d   = 1'b1;
    rdy_d  = 1'b1;
    qreq_d = 1'b0;
    case (nxt)
      RUN:      begin en_d = 1'b1; rdy_d = 1'b1; qreq_d = 1'b0; end
      IDLE_CNT: begin en_d = 1'b1; rdy_d = 1'b1; qreq_d = 1'b0; end
      QUIESCE:  begin en_d = 1'b1; rdy_d = 1'b0; qreq_d = 1'b1; end
      OFF:      begin en_d = 1'b0; rdy_d = 1'b0; qreq_d = 1'b0; end
      WAKE:     begin en_d = 1'b1; rdy_d = 1'b0; qreq_d = 1'b0; end
      default:  begin en_d = 1'b1; rdy_d = 1'b1; qreq_d = 1'b0; end
    endcase
  end

  assign gif.clk_en      = en_q;
  assign gif.clk_ready   = rdy_q;
  assign gif.quiesce_req = qreq_q;
  assign gif.state       = cur;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with hand-computed edge-by-edge expectations.
module tb_clk_gate_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  clk_gate_if #(.CNT_W(8)) gif();

  clk_gate_ctrl #(.CNT_W(8), .WAKE_DLY(2)) dut (
    .clk(clk), .rst_n(rst_n), .gif(gif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ae, input logic bz, input logic wk, input logic [7:0] th, input logic ak);
    gif.auto_en = ae; gif.busy = bz; gif.wake = wk; gif.idle_thresh = th; gif.quiesce_ack = ak;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b1, 1'b1, 8'd4, 1'b1);
    apply_reset();
    rst_n = 1'b0;
    tick();
    total++; if (gif.state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", gif.state); end
    total++; if (gif.clk_en !== 1'b1) begin bad++; $display("FAIL rst_clk_en got=%0b want=1", gif.clk_en); end
    total++; if (gif.clk_ready !== 1'b1) begin bad++; $display("FAIL rst_clk_ready got=%0b want=1", gif.clk_ready); end
    total++; if (gif.quiesce_req !== 1'b0) begin bad++; $display("FAIL rst_qreq got=%0b want=0", gif.quiesce_req); end
  endtask

  task automatic test_idle_gate();
    logic [2:0] exp;
    set_in(1'b1, 1'b0, 1'b0, 8'd4, 1'b0);
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp = (i < 5) ? 3'd1 : 3'd2;
      total++; if (gif.state !== exp) begin bad++; $display("FAIL gate_state[%0d] got=%0d want=%0d", i, gif.state, exp); end
      total++; if (gif.quiesce_req !== (i == 5)) begin bad++; $display("FAIL gate_qreq[%0d] got=%0b want=%0b", i, gif.quiesce_req, (i == 5)); end
    end
    total++; if (gif.clk_ready !== 1'b0) begin bad++; $display("FAIL gate_rdy_q got=%0b want=0", gif.clk_ready); end
    gif.quiesce_ack = 1'b1;
    tick();
    gif.quiesce_ack = 1'b0;
    total++; if (gif.state !== 3'd3) begin bad++; $display("FAIL gate_off_state got=%0d want=3", gif.state); end
    total++; if (gif.clk_en !== 1'b0) begin bad++; $display("FAIL gate_off_en got=%0b want=0", gif.clk_en); end
    tick();
    total++; if (gif.clk_en !== 1'b0) begin bad++; $display("FAIL gate_off_hold got=%0b want=0", gif.clk_en); end
  endtask

  // Continues from OFF left by test_idle_gate.
  task automatic test_wake_seq();
    logic [2:0] exp;
    gif.wake = 1'b1;
    tick();
    gif.wake = 1'b0;
    total++; if (gif.state !== 3'd4) begin bad++; $display("FAIL wake_state0 got=%0d want=4", gif.state); end
    total++; if (gif.clk_en !== 1'b1) begin bad++; $display("FAIL wake_en0 got=%0b want=1", gif.clk_en); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp = (i < 3) ? 3'd4 : 3'd0;
      total++; if (gif.state !== exp) begin bad++; $display("FAIL wake_state[%0d] got=%0d want=%0d", i, gif.state, exp); end
      total++; if (gif.clk_ready !== (i == 3)) begin bad++; $display("FAIL wake_rdy[%0d] got=%0b want=%0b", i, gif.clk_ready, (i == 3)); end
    end
  endtask

  task automatic test_busy_restart();
    logic [2:0] exp;
    set_in(1'b1, 1'b0, 1'b0, 8'd4, 1'b0);
    apply_reset();
    tick(); tick(); tick();
    total++; if (gif.state !== 3'd1) begin bad++; $display("FAIL br_idle got=%0d want=1", gif.state); end
    gif.busy = 1'b1;
    tick();
    gif.busy = 1'b0;
    total++; if (gif.state !== 3'd0) begin bad++; $display("FAIL br_run got=%0d want=0", gif.state); end
    gif.quiesce_ack = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) gif.quiesce_ack = 1'b0;
      tick();
      exp = (i < 5) ? 3'd1 : 3'd2;
      total++; if (gif.state !== exp) begin bad++; $display("FAIL br_state[%0d] got=%0d want=%0d", i, gif.state, exp); end
      total++; if (gif.quiesce_req !== (i == 5)) begin bad++; $display("FAIL br_qreq[%0d] got=%0b want=%0b", i, gif.quiesce_req, (i == 5)); end
    end
  endtask

  // Continues from QUIESCE left by test_busy_restart.
  task automatic test_wake_vs_ack();
    gif.wake = 1'b1; gif.quiesce_ack = 1'b1;
    tick();
    gif.wake = 1'b0; gif.quiesce_ack = 1'b0;
    total++; if (gif.state !== 3'd0) begin bad++; $display("FAIL wva_state got=%0d want=0", gif.state); end
    total++; if (gif.quiesce_req !== 1'b0) begin bad++; $display("FAIL wva_qreq got=%0b want=0", gif.quiesce_req); end
    total++; if (gif.clk_en !== 1'b1) begin bad++; $display("FAIL wva_en got=%0b want=1", gif.clk_en); end
  endtask

  task automatic test_auto_en_exits();
    set_in(1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
    apply_reset();
    tick();
    tick();
    total++; if (gif.state !== 3'd2) begin bad++; $display("FAIL th1_quiesce got=%0d want=2", gif.state); end
    gif.auto_en = 1'b0;
    tick();
    total++; if (gif.state !== 3'd0) begin bad++; $display("FAIL ae_q_abort got=%0d want=0", gif.state); end
    gif.auto_en = 1'b1;
    tick(); tick();
    gif.quiesce_ack = 1'b1;
    tick();
    gif.quiesce_ack = 1'b0;
    total++; if (gif.state !== 3'd3) begin bad++; $display("FAIL ae_off got=%0d want=3", gif.state); end
    gif.auto_en = 1'b0;
    tick();
    gif.auto_en = 1'b1;
    total++; if (gif.state !== 3'd4) begin bad++; $display("FAIL ae_off_wake got=%0d want=4", gif.state); end
  endtask

  task automatic test_thresh_max();
    set_in(1'b1, 1'b0, 1'b0, 8'd255, 1'b0);
    apply_reset();
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 255) begin
        total++; if (gif.state !== 3'd1) begin bad++; $display("FAIL max_pre got=%0d want=1", gif.state); end
      end
    end
    total++; if (gif.quiesce_req !== 1'b1) begin bad++; $display("FAIL max_qreq got=%0b want=1", gif.quiesce_req); end
  endtask

  task automatic test_thresh_zero();
    int bad_cyc = 0;
    set_in(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      tick();
      if (gif.state !== 3'd0 || gif.quiesce_req !== 1'b0) bad_cyc++;
    end
    total++; if (bad_cyc !== 0) begin bad++; $display("FAIL zero_thresh bad_cycles got=%0d want=0", bad_cyc); end
  endtask

  task automatic test_async_reset();
    set_in(1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
    apply_reset();
    tick(); tick();
    #3 rst_n = 1'b0;
    #1;
    total++; if ({gif.state, gif.clk_en, gif.clk_ready, gif.quiesce_req} !== 6'b000110) begin bad++; $display("FAIL arst_quiesce got=%b want=000110", {gif.state, gif.clk_en, gif.clk_ready, gif.quiesce_req}); end
    rst_n = 1'b1;
    tick(); tick();
    gif.quiesce_ack = 1'b1;
    tick();
    gif.quiesce_ack = 1'b0; gif.wake = 1'b1;
    tick();
    gif.wake = 1'b0;
    tick();
    total++; if (gif.state !== 3'd4) begin bad++; $display("FAIL arst_pre_wake got=%0d want=4", gif.state); end
    #3 rst_n = 1'b0;
    #1;
    total++; if ({gif.state, gif.clk_en, gif.clk_ready, gif.quiesce_req} !== 6'b000110) begin bad++; $display("FAIL arst_wake got=%b want=000110", {gif.state, gif.clk_en, gif.clk_ready, gif.quiesce_req}); end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    test_reset();
    test_idle_gate();
    test_wake_seq();
    test_busy_restart();
    test_wake_vs_ack();
    test_auto_en_exits();
    test_thresh_max();
    test_thresh_zero();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
